life_board_stepper: RTL and testbench

Sequential next-generation engine for the Game of Life board. It holds an N×N toroidal board and steps it one generation on command. Cells are evaluated one per clock: the engine gathers each cell's 8 neighbour bits, counts them with the existing neighbour counter, applies the B3/S23 rule into a shadow board, and commits the whole generation at once. It sits between the board loader/host and the display path, and consumes the 4-bit neighbour count that the counter produces.

---
 rtl/life_board_stepper_pkg.sv | 20 ++
 rtl/life_board_stepper_if.sv | 23 ++
 rtl/life_board_stepper_bit_counter.sv | 12 +
 rtl/life_board_stepper.sv | 107 ++++++++++
 tb/tb_life_board_stepper.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/life_board_stepper_pkg.sv
// Shared definitions for the Game of Life board stepper: FSM state codes,
// B3/S23 rule constants and a toroidal index wrap helper.
package life_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StScan   = 2'd1;
  localparam state_t StCommit = 2'd2;

  localparam logic [3:0] BIRTH_COUNT = 4'd3;
  localparam logic [3:0] SURVIVE_LO  = 4'd2;
  localparam logic [3:0] SURVIVE_HI  = 4'd3;

  // Valid for v in [-n, 2n), which covers every +/-1 neighbour offset.
  function automatic int wrap_idx(input int v, input int n);
    return (v + n) % n;
  endfunction

endpackage

// File: rtl/life_board_stepper_if.sv
// Command channel between the host/loader and the board stepper.
interface life_board_stepper_if #(
  parameter int N = 8
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_load;
  logic [N*N-1:0] load_board;

  modport master (
    output cmd_valid,
    output cmd_load,
    output load_board,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_load,
    input  load_board,
    output cmd_ready
  );
endinterface

// File: rtl/life_board_stepper_bit_counter.sv
// Eight-input population counter used for the neighbour count (result 0..8).
module bit_counter (
  input  logic [7:0] in,
  output logic [3:0] num
);
  always_comb begin
    num = '0;
    for (int i = 0; i < 8; i++) begin
      num = num + {3'b000, in[i]};
    end
  end
endmodule

// File: rtl/life_board_stepper.sv
// Sequential Game of Life engine: scans one cell per clock into a shadow
// board and commits the whole generation in a single cycle.
module life_board_stepper
  import life_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  life_board_stepper_if.slave  cmd,
  output logic [N*N-1:0]       board,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          generation
);

  localparam int RowW = $clog2(N);
  localparam int IdxW = $clog2(N*N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N*N-1);

  state_t         r_state;
  logic [N*N-1:0] r_board;
  logic [N*N-1:0] r_next;
  logic [IdxW-1:0] r_idx;
  logic [15:0]    r_gen;
  logic           r_done;

  logic [RowW-1:0] w_rn [3];
  logic [RowW-1:0] w_cn [3];
  logic [7:0]      w_nbrs;
  logic [3:0]      w_count;
  logic            w_alive;
  logic            w_next;
  logic            w_accept;

  // Row/column of the three neighbour lines around the current cell.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_rn[i] = RowW'(wrap_idx(int'(r_idx[IdxW-1:RowW]) + i - 1, N));
      w_cn[i] = RowW'(wrap_idx(int'(r_idx[RowW-1:0]) + i - 1, N));
    end
  end

  // N is a power of two, so {row, col} is exactly the flat cell index.
  assign w_nbrs = {r_board[{w_rn[0], w_cn[0]}], r_board[{w_rn[0], w_cn[1]}],
                   r_board[{w_rn[0], w_cn[2]}], r_board[{w_rn[1], w_cn[0]}],
                   r_board[{w_rn[1], w_cn[2]}], r_board[{w_rn[2], w_cn[0]}],
                   r_board[{w_rn[2], w_cn[1]}], r_board[{w_rn[2], w_cn[2]}]};

  bit_counter u_bit_counter (
    .in  (w_nbrs),
    .num (w_count)
  );

  assign w_alive  = r_board[r_idx];
  assign w_next   = (w_count == BIRTH_COUNT) ||
                    (w_alive && (w_count >= SURVIVE_LO) && (w_count <= SURVIVE_HI));
  assign w_accept = cmd.cmd_valid && (r_state == StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_board <= '0;
      r_next  <= '0;
      r_idx   <= '0;
      r_gen   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (cmd.cmd_load) begin
              r_board <= cmd.load_board;
              r_gen   <= '0;
            end else begin
              r_state <= StScan;
              r_idx   <= '0;
            end
          end
        end
        StScan: begin
          r_next[r_idx] <= w_next;
          if (r_idx == LastIdx) begin
            r_state <= StCommit;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StCommit: begin
          r_board <= r_next;
          r_gen   <= r_gen + 16'd1;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_ready = (r_state == StIdle);
  assign busy          = (r_state == StScan) || (r_state == StCommit);
  assign board         = r_board;
  assign done          = r_done;
  assign generation    = r_gen;

endmodule

// File: tb/tb_life_board_stepper.sv
// Directed bench for life_board_stepper (N=8): table of single-step patterns
// followed by hand sequences for back-to-back steps, stall, reset and wrap.
module tb_life_board_stepper;

  localparam int N = 8;

  typedef struct {
    string       name;
    logic [63:0] init;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] board;
  logic        busy;
  logic        done;
  logic [15:0] generation;

  int total = 0;
  int bad   = 0;

  life_board_stepper_if #(.N(N)) cmd_if ();

  life_board_stepper #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .board      (board),
    .busy       (busy),
    .done       (done),
    .generation (generation)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pt(input int r, input int c);
    return 64'd1 << (r * 8 + c);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [63:0] b);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_load   = 1'b1;
    cmd_if.load_board = b;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_load  = 1'b0;
  endtask

  // Returns edges from accept to the edge after which done is seen (0 = timeout).
  task automatic do_step(output int lat);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  vec_t        vecs[6];
  logic [63:0] blink_h, blink_v, wrap_v, wrap_h, blk;
  int          lat;

  initial begin
    blink_h = pt(3, 2) | pt(3, 3) | pt(3, 4);
    blink_v = pt(2, 3) | pt(3, 3) | pt(4, 3);
    wrap_v  = pt(7, 0) | pt(0, 0) | pt(1, 0);
    wrap_h  = pt(0, 7) | pt(0, 0) | pt(0, 1);
    blk     = pt(1, 1) | pt(1, 2) | pt(2, 1) | pt(2, 2);

    vecs[0] = '{"blinker_h", blink_h, blink_v};
    vecs[1] = '{"blinker_v", blink_v, blink_h};
    vecs[2] = '{"all_ones", {64{1'b1}}, 64'd0};
    vecs[3] = '{"empty", 64'd0, 64'd0};
    vecs[4] = '{"wrap", wrap_v, wrap_h};
    vecs[5] = '{"block", blk, blk};

    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_load   = 1'b1;
    cmd_if.load_board = {64{1'b1}};
    repeat (3) @(negedge clk);
    check("rst_board", board, 64'd0);
    check("rst_gen", 64'(generation), 64'd0);
    check("rst_ready", 64'(cmd_if.cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_load  = 1'b0;
    rst = 1'b1;

    foreach (vecs[i]) begin
      do_load(vecs[i].init);
      check({vecs[i].name, "_load"}, board, vecs[i].init);
      check({vecs[i].name, "_load_gen"}, 64'(generation), 64'd0);
      check({vecs[i].name, "_load_ready"}, 64'(cmd_if.cmd_ready), 64'd1);
      do_step(lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd65);
      check({vecs[i].name, "_board"}, board, vecs[i].exp);
      check({vecs[i].name, "_gen"}, 64'(generation), 64'd1);
      check({vecs[i].name, "_busy"}, 64'(busy), 64'd0);
    end

    // Blinker oscillates back across two steps.
    do_load(blink_h);
    do_step(lat);
    do_step(lat);
    check("blink2_board", board, blink_h);
    check("blink2_gen", 64'(generation), 64'd2);

    do_load({64{1'b1}});
    do_step(lat);
    do_step(lat);
    check("ones2_board", board, 64'd0);
    check("ones2_gen", 64'(generation), 64'd2);

    // Load offered throughout SCAN must be ignored.
    do_load(blink_h);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_load   = 1'b1;
    cmd_if.load_board = {64{1'b1}};
    check("stall_ready", 64'(cmd_if.cmd_ready), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_load  = 1'b0;
    check("stall_latency", 64'(lat), 64'd65);
    check("stall_board", board, blink_v);
    check("stall_gen", 64'(generation), 64'd1);

    // Asynchronous reset in the middle of SCAN.
    do_load(blink_h);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("arst_board", board, 64'd0);
    check("arst_gen", 64'(generation), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(cmd_if.cmd_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    do_load(blk);
    check("post_rst_load", board, blk);
    repeat (70) @(negedge clk);
    check("post_rst_no_commit", board, blk);
    check("post_rst_no_done", 64'(done), 64'd0);

    // Generation counter wrap.
    @(negedge clk);
    force dut.r_gen = 16'hFFFF;
    #1;
    release dut.r_gen;
    #1;
    check("gen_preset", 64'(generation), 64'hFFFF);
    do_step(lat);
    check("wrap_latency", 64'(lat), 64'd65);
    check("wrap_gen", 64'(generation), 64'd0);
    check("wrap_done_hi", 64'(done), 64'd1);
    @(negedge clk);
    check("wrap_done_lo", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
